fan_ctrl: RTL and testbench
===========================

FAN_CTRL -- requirements
Module: fan_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 4, number of fan channels (legal 1..4).
REQ-002 SHALL have parameter PWM_W, default 10, PWM counter width in bits (legal 4..16).
REQ-003 SHALL have parameter WIN_CNT, default 50000000, tach measurement window length in clocks (legal 16..2^27).
REQ-004 SHALL have parameter FLT_LEN, default 3, tach glitch-filter length in samples (legal 1..15).
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 CLK_I  in  1  system clock.
REQ-007 RST_N_I  in  1  asynchronous active-low reset.
REQ-008 FAN_STB_I  in  1  bus strobe.
REQ-009 FAN_WE_I  in  1  1 = write, 0 = read.
REQ-010 FAN_ADR_I  in  6  byte address.
REQ-011 FAN_DAT_I  in  32  write data.
REQ-012 FAN_ACK_O  out  1  bus acknowledge.
REQ-013 FAN_DAT_O  out  32  read data, valid while FAN_ACK_O = 1.
REQ-014 PWM_O  out  NCH  per-channel PWM drive.
REQ-015 TACH_I  in  NCH  per-channel tach input, asynchronous.
REQ-016 FAN_INT_O  out  1  stall interrupt, level.

Function
REQ-017 FAN_ACK_O SHALL rise the cycle after FAN_STB_I=1 with FAN_ACK_O=0, and SHALL fall the next cycle; each access SHALL take effect exactly once, in the cycle FAN_ACK_O rises.
REQ-018 Register map:
- 0x00 CTRL: [3:0] channel enable, [11:8] stall irq mask (1 = enabled).
- 0x04 STAT: [3:0] stall flags, write-1-to-clear.
- 0x08 STALL_MIN: [23:0].
- 0x10+4*ch DUTY: [PWM_W:0].
- 0x20+4*ch TACH: [23:0], read-only.
REQ-019 Bits and channels at or above NCH SHALL read 0 and ignore writes; unmapped addresses SHALL read 0 and ignore writes.
REQ-020 Read data SHALL be registered and presented on FAN_DAT_O with FAN_ACK_O; FAN_DAT_O SHALL be 0 when FAN_ACK_O=0.
REQ-021 A free-running PWM_W-bit counter SHALL wrap from 2^PWM_W-1 to 0.
REQ-022 DUTY writes greater than 2^PWM_W SHALL saturate to 2^PWM_W.
REQ-023 Each channel SHALL hold a shadow duty, loaded from DUTY in the cycle the counter wraps to 0, so duty changes only on period boundaries.
REQ-024 PWM_O[ch] SHALL be registered, equal to enable[ch] && (counter < shadow[ch]).
- Duty 0 gives constant 0.
- Duty 2^PWM_W gives constant 1.
REQ-025 Clearing enable[ch] SHALL force PWM_O[ch]=0 on the next cycle, without waiting for the period boundary.
REQ-026 Each TACH_I bit SHALL pass a 2-flop synchroniser, then a filter whose output changes only after FLT_LEN consecutive identical synchronised samples.
REQ-027 Each falling edge of a filtered tach signal SHALL increment that channel's 24-bit edge counter, saturating at 0xFFFFFF.
REQ-028 A shared window counter SHALL count 0..WIN_CNT-1; at WIN_CNT-1, every channel SHALL copy its edge count into TACH and restart its counter at 0.
- An edge in that same cycle SHALL restart the counter at 1 instead.
REQ-029 At each window end, an enabled channel whose new TACH value < STALL_MIN SHALL set stall[ch].
- Disabled channels SHALL never set their stall flag.
REQ-030 If a stall set and a W1C clear hit the same bit in the same cycle, set SHALL win.
REQ-031 FAN_INT_O SHALL be registered, equal to |(stall & mask), and SHALL update one cycle after a flag or mask change.
REQ-032 Edge and window counting SHALL continue during bus accesses; reads SHALL not disturb counters.

Reset
REQ-033 On RST_N_I=0, regardless of clock, the following SHALL be 0:
- outputs FAN_ACK_O, FAN_DAT_O, PWM_O, FAN_INT_O;
- all registers, shadows, counters and filter states.
REQ-034 After RST_N_I rises, the PWM and window counters SHALL start from 0 on the first clock edge; reset asserted mid-window SHALL discard the partial counts.

Verification
REQ-035 Setup PWM_W=4, NCH=2: CTRL=0x3, DUTY0=8, DUTY1=16 -> from the next counter wrap, PWM_O[0] is high 8 of every 16 clocks and PWM_O[1] is constantly high; DUTY0 readback = 8.
REQ-036 Write DUTY0=4 mid-period with counter=2 -> the current period keeps 8 high clocks; the next period has 4; a write of 40 reads back 16.
REQ-037 Setup WIN_CNT=100, FLT_LEN=3: drive TACH_I[0] with 5 clean falling edges plus 2 one-clock low glitches in a window -> TACH0 = 5 after the window end; an edge coinciding with the window end makes the next window count 1 higher.
REQ-038 STALL_MIN=3, CTRL=0x103, no edges on channel 1 -> STAT=0x2, FAN_INT_O=0 (mask bit 9 clear); set mask 0x300 -> FAN_INT_O=1 one cycle later; write STAT=0x2 -> FAN_INT_O=0, except when the clear coincides with a window end, where the flag stays 1.
REQ-039 Read address 0x3C and channel-3 registers with NCH=2 -> 0, with FAN_ACK_O high exactly one cycle per strobe.
REQ-040 Assert RST_N_I asynchronously mid-window with PWM high -> all outputs 0 immediately; TACH reads 0 after release.

Source files
------------

// File: rtl/fan_ctrl_if.sv
// Bus interface for fan_ctrl.
//   FAN_STB_I  strobe, held by the master until it sees FAN_ACK_O
//   FAN_WE_I   1 = write, 0 = read
//   FAN_ADR_I  byte address
//   FAN_DAT_I  write data
//   FAN_ACK_O  single-cycle acknowledge
//   FAN_DAT_O  read data, valid only while FAN_ACK_O is high (0 otherwise)
interface fan_ctrl_if;
  logic        FAN_STB_I;
  logic        FAN_WE_I;
  logic [5:0]  FAN_ADR_I;
  logic [31:0] FAN_DAT_I;
  logic        FAN_ACK_O;
  logic [31:0] FAN_DAT_O;

  modport master (
    output FAN_STB_I, FAN_WE_I, FAN_ADR_I, FAN_DAT_I,
    input  FAN_ACK_O, FAN_DAT_O
  );

  modport slave (
    input  FAN_STB_I, FAN_WE_I, FAN_ADR_I, FAN_DAT_I,
    output FAN_ACK_O, FAN_DAT_O
  );
endinterface

// File: rtl/fan_ctrl.sv
// Multi-channel fan controller: per-channel PWM drive with period-aligned
// duty updates, tach glitch filtering and windowed edge counting, stall
// detection and a level interrupt.
//   CLK_I      system clock
//   RST_N_I    asynchronous active-low reset
//   bus        register access (fan_ctrl_if.slave)
//   PWM_O      per-channel PWM output (registered)
//   TACH_I     per-channel tach input (asynchronous)
//   FAN_INT_O  stall interrupt, |(stall & mask), registered
// Registers: 0x00 CTRL, 0x04 STAT (W1C), 0x08 STALL_MIN,
//            0x10+4*ch DUTY, 0x20+4*ch TACH (read-only).
module fan_ctrl #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned PWM_W   = 10,
  parameter int unsigned WIN_CNT = 50000000,
  parameter int unsigned FLT_LEN = 3
) (
  input  logic           CLK_I,
  input  logic           RST_N_I,
  fan_ctrl_if.slave      bus,
  output logic [NCH-1:0] PWM_O,
  input  logic [NCH-1:0] TACH_I,
  output logic           FAN_INT_O
);

  localparam int unsigned      WIN_W    = $clog2(WIN_CNT);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CNT - 1);
  localparam logic [3:0]       FLT_LAST = 4'(FLT_LEN - 1);
  localparam logic [31:0]      DUTY_MAX = 32'(1) << PWM_W;

  // Bus side
  logic           r_ack;
  logic [31:0]    r_dat;
  logic [31:0]    w_rdata;
  logic           w_acc;
  logic           w_wr;
  logic [1:0]     w_ch;
  logic           w_ch_ok;
  logic           w_sel_ctrl;
  logic           w_sel_stat;
  logic           w_sel_smin;
  logic           w_sel_duty;
  logic           w_sel_tach;
  logic [PWM_W:0] w_duty_wdata;

  // Configuration
  logic [NCH-1:0] r_en;
  logic [NCH-1:0] r_mask;
  logic [23:0]    r_smin;
  logic [PWM_W:0] r_duty   [NCH];

  // PWM
  logic [PWM_W-1:0] r_cnt;
  logic [PWM_W:0]   r_shadow [NCH];
  logic [NCH-1:0]   r_pwm;

  // Tach
  logic [NCH-1:0]   r_sync1;
  logic [NCH-1:0]   r_sync2;
  logic [NCH-1:0]   r_flt;
  logic [3:0]       r_fcnt [NCH];
  logic [23:0]      r_edge [NCH];
  logic [23:0]      r_tach [NCH];
  logic [WIN_W-1:0] r_win;
  logic             w_win_end;
  logic [NCH-1:0]   w_fall;

  // Stall / interrupt
  logic [NCH-1:0] r_stall;
  logic [NCH-1:0] w_set;
  logic [NCH-1:0] w_clr;
  logic           r_int;

  // An access is taken only on the first strobe cycle; the ack cycle that
  // follows is never a second access even if the strobe is still high.
  assign w_acc      = bus.FAN_STB_I & ~r_ack;
  assign w_wr       = w_acc & bus.FAN_WE_I;
  assign w_ch       = bus.FAN_ADR_I[3:2];
  assign w_ch_ok    = (32'(w_ch) < NCH);
  assign w_sel_ctrl = (bus.FAN_ADR_I == 6'h00);
  assign w_sel_stat = (bus.FAN_ADR_I == 6'h04);
  assign w_sel_smin = (bus.FAN_ADR_I == 6'h08);
  assign w_sel_duty = (bus.FAN_ADR_I[5:4] == 2'b01) && (bus.FAN_ADR_I[1:0] == 2'b00) && w_ch_ok;
  assign w_sel_tach = (bus.FAN_ADR_I[5:4] == 2'b10) && (bus.FAN_ADR_I[1:0] == 2'b00) && w_ch_ok;
  assign w_duty_wdata = (bus.FAN_DAT_I > DUTY_MAX) ? DUTY_MAX[PWM_W:0] : bus.FAN_DAT_I[PWM_W:0];

  always_comb begin
    w_rdata = '0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      if (w_sel_ctrl) begin
        w_rdata[ch]     = r_en[ch];
        w_rdata[8 + ch] = r_mask[ch];
      end
      if (w_sel_stat) w_rdata[ch] = r_stall[ch];
      if (w_sel_duty && (w_ch == 2'(ch))) w_rdata[PWM_W:0] = r_duty[ch];
      if (w_sel_tach && (w_ch == 2'(ch))) w_rdata[23:0] = r_tach[ch];
    end
    if (w_sel_smin) w_rdata[23:0] = r_smin;
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= (w_acc && !bus.FAN_WE_I) ? w_rdata : '0;
    end
  end

  assign bus.FAN_ACK_O = r_ack;
  assign bus.FAN_DAT_O = r_dat;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_en   <= '0;
      r_mask <= '0;
      r_smin <= '0;
      for (int unsigned ch = 0; ch < NCH; ch++) r_duty[ch] <= '0;
    end else if (w_wr) begin
      if (w_sel_ctrl) begin
        r_en   <= bus.FAN_DAT_I[NCH-1:0];
        r_mask <= bus.FAN_DAT_I[8 +: NCH];
      end
      if (w_sel_smin) r_smin <= bus.FAN_DAT_I[23:0];
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        if (w_sel_duty && (w_ch == 2'(ch))) r_duty[ch] <= w_duty_wdata;
      end
    end
  end

  // Shadow reload happens on the edge that takes the counter from all-ones
  // to 0, so the new duty governs the whole of the following period.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_cnt <= '0;
      r_pwm <= '0;
      for (int unsigned ch = 0; ch < NCH; ch++) r_shadow[ch] <= '0;
    end else begin
      r_cnt <= r_cnt + PWM_W'(1);
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        if (&r_cnt) r_shadow[ch] <= r_duty[ch];
        r_pwm[ch] <= r_en[ch] & ({1'b0, r_cnt} < r_shadow[ch]);
      end
    end
  end

  assign PWM_O     = r_pwm;
  assign w_win_end = (r_win == WIN_LAST);

  // A falling edge is the filter output switching 1 -> 0 on this clock.
  always_comb begin
    w_fall = '0;
    w_set  = '0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      w_fall[ch] = r_flt[ch] & ~r_sync2[ch] & (r_fcnt[ch] == FLT_LAST);
      w_set[ch]  = w_win_end & r_en[ch] & (r_edge[ch] < r_smin);
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_flt   <= '0;
      r_win   <= '0;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        r_fcnt[ch] <= '0;
        r_edge[ch] <= '0;
        r_tach[ch] <= '0;
      end
    end else begin
      r_sync1 <= TACH_I;
      r_sync2 <= r_sync1;
      r_win   <= w_win_end ? '0 : r_win + WIN_W'(1);
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        // Count consecutive samples that disagree with the filtered level;
        // any agreeing sample restarts the run.
        if (r_sync2[ch] != r_flt[ch]) begin
          if (r_fcnt[ch] == FLT_LAST) begin
            r_flt[ch]  <= r_sync2[ch];
            r_fcnt[ch] <= '0;
          end else begin
            r_fcnt[ch] <= r_fcnt[ch] + 4'd1;
          end
        end else begin
          r_fcnt[ch] <= '0;
        end
        // An edge on the window-end clock belongs to the next window.
        if (w_win_end) begin
          r_tach[ch] <= r_edge[ch];
          r_edge[ch] <= w_fall[ch] ? 24'd1 : 24'd0;
        end else if (w_fall[ch] && (r_edge[ch] != '1)) begin
          r_edge[ch] <= r_edge[ch] + 24'd1;
        end
      end
    end
  end

  assign w_clr = (w_wr && w_sel_stat) ? bus.FAN_DAT_I[NCH-1:0] : '0;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_stall <= '0;
      r_int   <= 1'b0;
    end else begin
      r_stall <= (r_stall & ~w_clr) | w_set;  // set wins over clear
      r_int   <= |(r_stall & r_mask);
    end
  end

  assign FAN_INT_O = r_int;

endmodule

// File: tb/tb_fan_ctrl.sv
// Directed self-checking bench for fan_ctrl (NCH=2, PWM_W=4, WIN_CNT=100, FLT_LEN=3).
module tb_fan_ctrl;
  localparam int unsigned NCH = 2;
  localparam int unsigned PWM_W = 4;
  localparam int unsigned WIN = 100;
  localparam int unsigned FLT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fan_ctrl_if bus();
  logic [NCH-1:0] pwm;
  logic [NCH-1:0] tach;
  logic           irq;

  logic tach_man0 = 1'b1;
  logic tach_run  = 1'b0;
  logic tach_gen  = 1'b1;
  int   gcnt      = 0;
  assign tach = {1'b0, (tach_run ? tach_gen : tach_man0)};

  fan_ctrl #(.NCH(NCH), .PWM_W(PWM_W), .WIN_CNT(WIN), .FLT_LEN(FLT)) dut (
    .CLK_I(clk), .RST_N_I(rst_n), .bus(bus),
    .PWM_O(pwm), .TACH_I(tach), .FAN_INT_O(irq)
  );

  // Reference counters: PWM counter and window counter as they should run.
  logic [3:0]  m_cnt;
  int unsigned m_win;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= '0;
      m_win <= 0;
    end else begin
      m_cnt <= m_cnt + 4'd1;
      m_win <= (m_win == WIN - 1) ? 0 : m_win + 1;
    end
  end

  // Background tach source: 12-clock period, ~8 falling edges per window.
  always @(negedge clk) begin
    if (tach_run) begin
      if (gcnt == 5) begin
        gcnt <= 0;
        tach_gen <= ~tach_gen;
      end else begin
        gcnt <= gcnt + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic a1, a2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Bus helpers: called right after a negedge, return right after a negedge.
  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
    bus.FAN_STB_I = 1'b1; bus.FAN_WE_I = 1'b1; bus.FAN_ADR_I = a; bus.FAN_DAT_I = d;
    @(negedge clk);
    bus.FAN_STB_I = 1'b0; bus.FAN_WE_I = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [31:0] d, output logic k1, output logic k2);
    bus.FAN_STB_I = 1'b1; bus.FAN_WE_I = 1'b0; bus.FAN_ADR_I = a;
    @(negedge clk);
    d = bus.FAN_DAT_O; k1 = bus.FAN_ACK_O;
    bus.FAN_STB_I = 1'b0;
    @(negedge clk);
    k2 = bus.FAN_ACK_O;
  endtask

  task automatic wait_win(input int unsigned tgt);
    int unsigned n = 0;
    while (m_win != tgt && n < 250) begin @(negedge clk); n++; end
    if (m_win != tgt) begin errors++; $display("FAIL wait_win: got %0d expected %0d", m_win, tgt); end
  endtask

  task automatic align_pwm();
    int unsigned n = 0;
    while (m_cnt != 4'd1 && n < 40) begin @(negedge clk); n++; end
    if (m_cnt != 4'd1) begin errors++; $display("FAIL align_pwm: got %0d expected 1", m_cnt); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (pwm !== 2'b00) begin errors++; $display("FAIL rst_pwm: got %b expected 00", pwm); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
    checks++; if (bus.FAN_ACK_O !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", bus.FAN_ACK_O); end
    checks++; if (bus.FAN_DAT_O !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h expected 0", bus.FAN_DAT_O); end
    rst_n = 1'b1;
    bus_rd(6'h00, rd, a1, a2);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h expected 0", rd); end
    checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin errors++; $display("FAIL rst_ack_pulse: got %b%b expected 10", a1, a2); end
    bus_rd(6'h10, rd, a1, a2);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_duty0: got %h expected 0", rd); end
  endtask

  task automatic test_pwm();
    logic [15:0] s0, s1;
    bus_wr(6'h00, 32'h3);
    bus_wr(6'h10, 32'd8);
    bus_wr(6'h14, 32'd16);
    bus_rd(6'h10, rd, a1, a2);
    checks++; if (rd !== 32'd8) begin errors++; $display("FAIL duty0_rb: got %h expected 8", rd); end
    repeat (20) @(negedge clk);
    align_pwm();
    for (int i = 0; i < 16; i++) begin
      s0[i] = pwm[0]; s1[i] = pwm[1];
      @(negedge clk);
    end
    checks++; if (s0 !== 16'h00FF) begin errors++; $display("FAIL pwm0_pattern: got %h expected 00ff", s0); end
    checks++; if (s1 !== 16'hFFFF) begin errors++; $display("FAIL pwm1_pattern: got %h expected ffff", s1); end
  endtask

  task automatic test_duty_update();
    logic [31:0] s0;
    align_pwm();
    fork
      for (int i = 0; i < 32; i++) begin
        s0[i] = pwm[0];
        @(negedge clk);
      end
      begin
        @(negedge clk);
        bus_wr(6'h10, 32'd4);
      end
    join
    checks++; if (s0 !== 32'h000F00FF) begin errors++; $display("FAIL duty_boundary: got %h expected 000f00ff", s0); end
    bus_wr(6'h10, 32'd40);
    bus_rd(6'h10, rd, a1, a2);
    checks++; if (rd !== 32'd16) begin errors++; $display("FAIL duty_sat: got %h expected 10", rd); end
  endtask

  task automatic test_tach();
    wait_win(1);
    for (int i = 0; i < 5; i++) begin
      tach_man0 = 1'b0; repeat (6) @(negedge clk);
      tach_man0 = 1'b1;
      if (i == 1 || i == 3) begin
        repeat (4) @(negedge clk);
        tach_man0 = 1'b0; @(negedge clk);
        tach_man0 = 1'b1; repeat (3) @(negedge clk);
      end else begin
        repeat (6) @(negedge clk);
      end
    end
    wait_win(95);
    tach_man0 = 1'b0;   // filtered fall lands exactly on the window-end clock
    wait_win(2);
    bus_rd(6'h20, rd, a1, a2);
    checks++; if (rd !== 32'd5) begin errors++; $display("FAIL tach0_count: got %0d expected 5", rd); end
    bus_rd(6'h24, rd, a1, a2);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL tach1_count: got %0d expected 0", rd); end
    wait_win(95);
    wait_win(2);
    bus_rd(6'h20, rd, a1, a2);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL tach0_carry: got %0d expected 1", rd); end
    tach_man0 = 1'b1;
  endtask

  task automatic test_stall();
    tach_run = 1'b1;
    wait_win(50); wait_win(2);
    bus_wr(6'h08, 32'd3);
    bus_wr(6'h00, 32'h103);
    wait_win(50); wait_win(2);
    bus_rd(6'h04, rd, a1, a2);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL stat_stall: got %h expected 2", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b expected 0", irq); end
    bus.FAN_STB_I = 1'b1; bus.FAN_WE_I = 1'b1; bus.FAN_ADR_I = 6'h00; bus.FAN_DAT_I = 32'h303;
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b expected 0", irq); end
    bus.FAN_STB_I = 1'b0; bus.FAN_WE_I = 1'b0;
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmask: got %b expected 1", irq); end
    bus_wr(6'h04, 32'h2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
    bus_rd(6'h04, rd, a1, a2);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL stat_clear: got %h expected 0", rd); end
    wait_win(99);
    bus_wr(6'h04, 32'h2);   // clear lands on the window-end clock
    bus_rd(6'h04, rd, a1, a2);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL set_wins: got %h expected 2", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b expected 1", irq); end
  endtask

  task automatic test_disabled();
    bus_wr(6'h00, 32'h301);
    checks++; if (pwm[1] !== 1'b0) begin errors++; $display("FAIL pwm1_disable: got %b expected 0", pwm[1]); end
    bus_wr(6'h04, 32'h3);
    wait_win(50); wait_win(2);
    bus_rd(6'h04, rd, a1, a2);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL stat_disabled: got %h expected 0", rd); end
    bus_wr(6'h00, 32'h303);
    wait_win(50); wait_win(2);
    bus_rd(6'h04, rd, a1, a2);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL stat_reenabled: got %h expected 2", rd); end
  endtask

  task automatic test_unmapped();
    bus_rd(6'h3C, rd, a1, a2);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd_3c: got %h expected 0", rd); end
    checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin errors++; $display("FAIL ack_3c: got %b%b expected 10", a1, a2); end
    bus_wr(6'h1C, 32'd5);
    bus_rd(6'h1C, rd, a1, a2);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd_duty3: got %h expected 0", rd); end
    checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin errors++; $display("FAIL ack_duty3: got %b%b expected 10", a1, a2); end
    bus_rd(6'h2C, rd, a1, a2);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd_tach3: got %h expected 0", rd); end
    bus_wr(6'h00, 32'hFFFF_FFFF);
    bus_rd(6'h00, rd, a1, a2);
    checks++; if (rd !== 32'h303) begin errors++; $display("FAIL ctrl_upper: got %h expected 303", rd); end
  endtask

  task automatic test_async_reset();
    wait_win(50);
    checks++; if (pwm[1] !== 1'b1) begin errors++; $display("FAIL pre_rst_pwm1: got %b expected 1", pwm[1]); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_rst_irq: got %b expected 1", irq); end
    bus.FAN_STB_I = 1'b1; bus.FAN_WE_I = 1'b0; bus.FAN_ADR_I = 6'h20;
    @(negedge clk);
    checks++; if (bus.FAN_ACK_O !== 1'b1) begin errors++; $display("FAIL pre_rst_ack: got %b expected 1", bus.FAN_ACK_O); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pwm !== 2'b00) begin errors++; $display("FAIL arst_pwm: got %b expected 00", pwm); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arst_irq: got %b expected 0", irq); end
    checks++; if (bus.FAN_ACK_O !== 1'b0) begin errors++; $display("FAIL arst_ack: got %b expected 0", bus.FAN_ACK_O); end
    checks++; if (bus.FAN_DAT_O !== 32'h0) begin errors++; $display("FAIL arst_dat: got %h expected 0", bus.FAN_DAT_O); end
    bus.FAN_STB_I = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_rd(6'h20, rd, a1, a2);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL arst_tach0: got %h expected 0", rd); end
    bus_rd(6'h04, rd, a1, a2);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL arst_stat: got %h expected 0", rd); end
  endtask

  initial begin
    bus.FAN_STB_I = 1'b0;
    bus.FAN_WE_I  = 1'b0;
    bus.FAN_ADR_I = '0;
    bus.FAN_DAT_I = '0;
    test_reset();
    test_pwm();
    test_duty_update();
    test_tach();
    test_stall();
    test_disabled();
    test_unmapped();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
